// File: rtl/stopwatch_counter.sv
// BCD mm:ss stopwatch with run/pause/adjust FSM, driven by 1 Hz count and 2 Hz adjust ticks.
// Latency: digits update on the edge where a tick is detected; no backpressure, and ticks are dropped unless they apply.
module stopwatch_counter #(
    parameter int MAX_MIN = 59
) (
    input  logic       i_clk_ref,
    input  logic       i_clk_res_n,
    input  logic       i_clk_1hz,
    input  logic       i_clk_2hz,
    input  logic       i_pause_p,
    input  logic       i_clear_p,
    input  logic       i_adj,
    input  logic       i_sel,
    output logic [3:0] o_min_tens,
    output logic [3:0] o_min_ones,
    output logic [3:0] o_sec_tens,
    output logic [3:0] o_sec_ones,
    output logic       o_blank_min,
    output logic       o_blank_sec,
    output logic       o_running,
    output logic       o_wrap
);

    typedef enum logic [1:0] {ST_PAUSE, ST_RUN, ST_ADJUST} state_t;

    localparam logic [3:0] MAX_MT = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_MO = 4'(MAX_MIN % 10);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_1hz_q;
    logic       r_2hz_q;
    logic [3:0] r_mt, r_mo, r_st, r_so;
    logic [3:0] w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt;
    logic       r_wrap;
    logic       w_wrap_nxt;
    logic       w_tick_1hz, w_tick_2hz;
    logic       w_run_tick, w_adj_tick;
    logic       w_inc_sec, w_inc_min;
    logic       w_sec_max, w_min_max;

    assign w_tick_1hz = i_clk_1hz & ~r_1hz_q;
    assign w_tick_2hz = i_clk_2hz & ~r_2hz_q;
    assign w_run_tick = (r_state == ST_RUN) && w_tick_1hz;
    assign w_adj_tick = (r_state == ST_ADJUST) && w_tick_2hz;
    assign w_sec_max  = (r_st == 4'd5) && (r_so == 4'd9);
    assign w_min_max  = (r_mt == MAX_MT) && (r_mo == MAX_MO);
    // Seconds carry into minutes only while running; adjust edits one field in isolation.
    assign w_inc_sec  = w_run_tick || (w_adj_tick && !i_sel);
    assign w_inc_min  = (w_run_tick && w_sec_max) || (w_adj_tick && i_sel);
    assign w_wrap_nxt = w_run_tick && w_sec_max && w_min_max && !i_clear_p;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_PAUSE: begin
                if (i_adj)          w_state_nxt = ST_ADJUST;
                else if (i_pause_p) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (i_adj)          w_state_nxt = ST_ADJUST;
                else if (i_pause_p) w_state_nxt = ST_PAUSE;
            end
            ST_ADJUST: begin
                if (!i_adj)         w_state_nxt = ST_PAUSE;
            end
            default:                w_state_nxt = ST_PAUSE;
        endcase
    end

    always_comb begin
        w_mt_nxt = r_mt;
        w_mo_nxt = r_mo;
        w_st_nxt = r_st;
        w_so_nxt = r_so;
        if (i_clear_p) begin
            w_mt_nxt = 4'd0;
            w_mo_nxt = 4'd0;
            w_st_nxt = 4'd0;
            w_so_nxt = 4'd0;
        end else begin
            if (w_inc_sec) begin
                if (r_so == 4'd9) begin
                    w_so_nxt = 4'd0;
                    w_st_nxt = (r_st == 4'd5) ? 4'd0 : r_st + 4'd1;
                end else begin
                    w_so_nxt = r_so + 4'd1;
                end
            end
            if (w_inc_min) begin
                if (w_min_max) begin
                    w_mt_nxt = 4'd0;
                    w_mo_nxt = 4'd0;
                end else if (r_mo == 4'd9) begin
                    w_mo_nxt = 4'd0;
                    w_mt_nxt = r_mt + 4'd1;
                end else begin
                    w_mo_nxt = r_mo + 4'd1;
                end
            end
        end
    end

    // Edge registers reset high so a level already high at release is not a tick.
    always_ff @(posedge i_clk_ref or negedge i_clk_res_n) begin
        if (!i_clk_res_n) begin
            r_state <= ST_PAUSE;
            r_1hz_q <= 1'b1;
            r_2hz_q <= 1'b1;
            r_mt    <= 4'd0;
            r_mo    <= 4'd0;
            r_st    <= 4'd0;
            r_so    <= 4'd0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_1hz_q <= i_clk_1hz;
            r_2hz_q <= i_clk_2hz;
            r_mt    <= w_mt_nxt;
            r_mo    <= w_mo_nxt;
            r_st    <= w_st_nxt;
            r_so    <= w_so_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign o_min_tens  = r_mt;
    assign o_min_ones  = r_mo;
    assign o_sec_tens  = r_st;
    assign o_sec_ones  = r_so;
    assign o_running   = (r_state == ST_RUN);
    assign o_wrap      = r_wrap;
    assign o_blank_sec = (r_state == ST_ADJUST) && !i_sel && r_2hz_q;
    assign o_blank_min = (r_state == ST_ADJUST) &&  i_sel && r_2hz_q;

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter MAX_MIN, default 59: highest minute value; minutes wrap MAX_MIN -> 0.
REQ-002 CLK_REF  input  1  system clock; all state changes on its rising edge.
REQ-003 CLK_RES_N  input  1  reset; asynchronous assert, active-low.
REQ-004 CLK_1HZ  input  1  1 Hz square wave from the clock divider, synchronous to CLK_REF; each rising edge is one count tick.
REQ-005 CLK_2HZ  input  1  2 Hz square wave from the clock divider, synchronous to CLK_REF; each rising edge is one adjust tick and its level drives blinking.
REQ-006 PAUSE_P  input  1  single-cycle pulse (already debounced); toggles run/pause.
REQ-007 CLEAR_P  input  1  single-cycle pulse (already debounced); clears time to 00:00.
REQ-008 ADJ  input  1  level; 1 = adjust mode.
REQ-009 SEL  input  1  level; adjust field select, 0 = seconds, 1 = minutes.
REQ-010 MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES  output  4 each  BCD time digits, registered.
REQ-011 BLANK_MIN, BLANK_SEC  output  1 each  1 = display blanks that field.
REQ-012 RUNNING  output  1  1 while in state RUN.
REQ-013 WRAP  output  1  single-cycle pulse when time rolls MAX_MIN:59 -> 00:00.

Function
REQ-014 Edge detection SHALL use one register per tick input; tick = input high AND registered copy low.
REQ-015 FSM states SHALL be PAUSE, RUN, ADJUST.
REQ-016 PAUSE: PAUSE_P -> RUN; ADJ=1 -> ADJUST; time held.
REQ-017 RUN: each CLK_1HZ tick increments time by one second; PAUSE_P -> PAUSE; ADJ=1 -> ADJUST.
REQ-018 ADJUST: each CLK_2HZ tick increments only the SEL field; no carry between fields; PAUSE_P ignored; ADJ=0 -> PAUSE.
REQ-019 ADJ=1 SHALL take priority over PAUSE_P in the same cycle.
REQ-020 Seconds SHALL count 00..59 in BCD; SEC_ONES 9 -> 0 increments SEC_TENS; 59 -> 00 carries +1 into minutes (RUN only).
REQ-021 Minutes SHALL count 00..MAX_MIN in BCD; MAX_MIN -> 00 wraps.
REQ-022 WRAP SHALL pulse high for exactly one cycle, coincident with the digit update, on RUN rollover MAX_MIN:59 -> 00:00; never in ADJUST.
REQ-023 Latency: digits SHALL update on the CLK_REF edge where the tick is detected, visible one cycle after the input is first sampled high.
REQ-024 CLEAR_P SHALL zero all four digits next edge in any state, leave the FSM state unchanged, and override a coincident tick; WRAP is not asserted.
REQ-025 PAUSE_P coincident with a RUN tick: the tick is applied, then the state becomes PAUSE.
REQ-026 Ticks arriving in PAUSE SHALL be discarded, not queued.
REQ-027 BLANK_SEC = ADJUST AND SEL=0 AND registered CLK_2HZ high; BLANK_MIN = ADJUST AND SEL=1 AND registered CLK_2HZ high; otherwise 0.
REQ-028 Digits SHALL never hold a value outside 0..9 (tens of seconds 0..5).

Reset
REQ-029 CLK_RES_N low SHALL immediately force: state PAUSE, all digits 0, RUNNING 0, WRAP 0, BLANK_* 0.
REQ-030 Edge-detect registers SHALL reset to 1, so an input already high at reset release produces no tick.
REQ-031 Reset mid-count SHALL discard the partial time; there is no resume.
REQ-032 Reset release SHALL be synchronous to CLK_REF; the first tick counts only after a full low-to-high input transition.

Verification
REQ-033 Reset; PAUSE_P; 75 CLK_1HZ rising edges -> 01:15, RUNNING=1.
REQ-034 Preload 59:58 in RUN with MAX_MIN=59; 2 ticks -> 59:59, then 00:00 with WRAP high for exactly 1 cycle.
REQ-035 RUN at 00:10; PAUSE_P coincident with tick -> 00:11, RUNNING=0; 5 more ticks -> still 00:11.
REQ-036 ADJ=1, SEL=1, at 00:59; 3 CLK_2HZ ticks -> 03:59 with seconds untouched; BLANK_MIN follows CLK_2HZ level, BLANK_SEC=0.
REQ-037 RUN at 12:34; CLEAR_P coincident with tick -> 00:00, RUNNING=1, WRAP=0.
REQ-038 CLK_1HZ held high across reset release -> no increment until the next low-to-high edge; reset asserted mid-cycle clears outputs without waiting for a clock edge.
